// File: rtl/display_sched.sv
// Multiplexed display scheduler: scans a latched word one nibble per digit and
// hands the display to one of SRC_N requesters, switching only on frame boundaries.
//
// state | meaning
// IDLE  | no owner, gnt all-zero, data_display frozen
// SHOW  | one owner, its word recaptured every frame boundary
module display_sched #(
    parameter int WIDTH    = 32,
    parameter int SRC_N    = 4,
    parameter int SCAN_DIV = 16,
    parameter int DWELL    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SRC_N-1:0]       req,
    input  logic [SRC_N*WIDTH-1:0] src_data,
    input  logic                   hold,
    output logic [SRC_N-1:0]       gnt,
    output logic [WIDTH-1:0]       data_display,
    output logic [2:0]             an,
    output logic [3:0]             char,
    output logic                   frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW = $clog2(SRC_N);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FCNT_LAST  = FW'(DWELL - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t            state;
    logic [PW-1:0]     presc;
    logic [FW-1:0]     fcnt;
    logic [IW-1:0]     rr;
    logic [IW-1:0]     own;
    logic              tick;
    logic              fb;
    logic [WIDTH-1:0]  src_word [SRC_N];
    logic [SRC_N-1:0]  others;
    logic [IW-1:0]     own_inc;
    logic [IW-1:0]     first_idx;
    logic [IW-1:0]     next_idx;
    logic              grant_en;
    logic [IW-1:0]     grant_idx;
    logic              go_idle;
    logic [31:0]       padded;

    // First set bit of r, scanning upward from start with wrap.
    function automatic logic [IW-1:0] rr_pick(input logic [SRC_N-1:0] r,
                                              input logic [IW-1:0]    start);
        logic [IW-1:0] sel;
        logic [IW-1:0] idx;
        sel = start;
        for (int k = SRC_N - 1; k >= 0; k--) begin
            idx = IW'((int'(start) + k) % SRC_N);
            if (r[idx]) sel = idx;
        end
        return sel;
    endfunction

    for (genvar g = 0; g < SRC_N; g++) begin : g_unpack
        assign src_word[g] = src_data[g*WIDTH +: WIDTH];
    end

    always_comb begin
        tick      = (presc == PRESC_LAST);
        fb        = tick && (an == 3'd7);
        others    = req & ~gnt;
        own_inc   = IW'((int'(own) + 1) % SRC_N);
        first_idx = rr_pick(req, rr);
        next_idx  = rr_pick(others, own_inc);
    end

    // Arbitration outcome for the coming frame boundary; hold beats everything in SHOW.
    always_comb begin
        grant_en  = 1'b0;
        grant_idx = first_idx;
        go_idle   = 1'b0;
        if (state == IDLE) begin
            grant_en = |req;
        end else if (!hold) begin
            if (!req[own]) begin
                if (|others) begin
                    grant_en  = 1'b1;
                    grant_idx = next_idx;
                end else begin
                    go_idle = 1'b1;
                end
            end else if ((fcnt == FCNT_LAST) && (|others)) begin
                grant_en  = 1'b1;
                grant_idx = next_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            presc        <= '0;
            an           <= '0;
            fcnt         <= '0;
            rr           <= '0;
            own          <= '0;
            gnt          <= '0;
            data_display <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= fb;
            presc      <= tick ? '0 : presc + 1'b1;
            if (tick) an <= an + 3'd1;
            if (fb) begin
                if (grant_en) begin
                    state        <= SHOW;
                    own          <= grant_idx;
                    gnt          <= SRC_N'(1) << grant_idx;
                    rr           <= IW'((int'(grant_idx) + 1) % SRC_N);
                    fcnt         <= '0;
                    data_display <= src_word[grant_idx];
                end else if (go_idle) begin
                    state <= IDLE;
                    gnt   <= '0;
                end else if (state == SHOW) begin
                    data_display <= src_word[own];
                    if (!hold && (fcnt != FCNT_LAST)) fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // Nibbles beyond WIDTH read as zero through the padding.
    always_comb begin
        padded               = '0;
        padded[WIDTH-1:0]    = data_display;
        char                 = padded[{an, 2'b00} +: 4];
    end

endmodule

// File: tb/tb_display_sched.sv
// Randomized bench for display_sched: a frame-level reference model queues the
// expected owner/word per frame boundary; a monitor checks every cycle.
module tb_display_sched;

    localparam int W     = 32;
    localparam int N     = 4;
    localparam int SD    = 4;
    localparam int DW    = 2;
    localparam int FRAME = 8 * SD;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] src_data = '0;
    logic           hold = 1'b0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   data_display;
    logic [2:0]     an;
    logic [3:0]     char;
    logic           frame_done;

    display_sched #(.WIDTH(W), .SRC_N(N), .SCAN_DIV(SD), .DWELL(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .src_data     (src_data),
        .hold         (hold),
        .gnt          (gnt),
        .data_display (data_display),
        .an           (an),
        .char         (char),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Cycles since the last reset edge, counted by the bench itself.
    int k = 0;
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    typedef struct packed {
        logic [N-1:0] g;
        logic [W-1:0] d;
    } exp_t;
    exp_t q[$];

    int           m_own  = -1;
    int           m_fcnt = 0;
    int           m_rr   = 0;
    logic [W-1:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (k=%0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    function automatic int next_from(input logic [N-1:0] r, input int start);
        for (int j = 0; j < N; j++) begin
            if (r[(start + j) % N]) return (start + j) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_fcnt = 0;
        m_rr   = 0;
        m_data = '0;
        q.delete();
    endtask

    // Frame-boundary rules applied to the inputs that the boundary edge will see.
    task automatic model_fb();
        logic [N-1:0] oth;
        int           c;
        exp_t         e;
        if (m_own < 0) begin
            c = next_from(req, m_rr);
            if (c >= 0) begin
                m_own  = c;
                m_rr   = (c + 1) % N;
                m_fcnt = 0;
            end
        end else if (!hold) begin
            oth        = req;
            oth[m_own] = 1'b0;
            if (!req[m_own] || (m_fcnt == DW - 1 && oth != '0)) begin
                c = next_from(oth, (m_own + 1) % N);
                if (c >= 0) begin
                    m_own  = c;
                    m_rr   = (c + 1) % N;
                    m_fcnt = 0;
                end else begin
                    m_own = -1;
                end
            end else if (m_fcnt < DW - 1) begin
                m_fcnt++;
            end
        end
        if (m_own >= 0) m_data = src_data[m_own*W +: W];
        e.g = (m_own < 0) ? '0 : (N'(1) << m_own);
        e.d = m_data;
        q.push_back(e);
    endtask

    task automatic randomize_words();
        for (int j = 0; j < N; j++) src_data[j*W +: W] = $urandom;
    endtask

    // One frame of stimulus starting at a negedge; rst_at >= 0 pulses reset there.
    task automatic run_frame(input logic [N-1:0] r, input logic h,
                             input logic [W-1:0] d0, input bit use_d0, input int rst_at);
        int chg;
        chg = $urandom_range(0, FRAME - 1);
        for (int i = 0; i < FRAME; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                return;
            end
            if (!use_d0 && $urandom_range(0, 7) == 0) randomize_words();
            if (i == chg) begin
                req  = r;
                hold = h;
                randomize_words();
                if (use_d0) src_data[W-1:0] = d0;
            end
            if (i == FRAME - 1) model_fb();
            @(negedge clk);
        end
    endtask

    // Monitor: pops one expectation per frame_done and checks every cycle.
    initial begin
        logic [N-1:0] cg;
        logic [W-1:0] cd;
        int           ea;
        exp_t         e;
        cg = '0;
        cd = '0;
        forever begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                cg = '0;
                cd = '0;
            end
            if (frame_done === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_pop: frame_done with no expectation queued (k=%0d)", k);
                end else begin
                    e  = q.pop_front();
                    cg = e.g;
                    cd = e.d;
                end
            end
            ea = (k / SD) % 8;
            chk("frame_done", frame_done, (k > 0 && k % FRAME == 0) ? 1 : 0);
            chk("an", an, ea);
            chk("gnt", gnt, cg);
            chk("data_display", data_display, cd);
            chk("char", char, (cd >> (4 * ea)) & 32'hf);
        end
    end

    initial begin
        int rst_at;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Directed frames: idle, single source with data change, two-way
        // contention, owner drop, reset mid-frame, hold and hold-over-drop.
        repeat (3) run_frame(4'b0000, 1'b0, 32'h0, 1'b1, -1);
        run_frame(4'b0001, 1'b0, 32'h12345678, 1'b1, -1);
        run_frame(4'b0001, 1'b0, 32'hDEADBEEF, 1'b1, -1);
        repeat (6) run_frame(4'b0101, 1'b0, 32'hA5A5_0001, 1'b1, -1);
        run_frame(4'b0001, 1'b0, 32'h0000_1111, 1'b1, -1);
        run_frame(4'b1000, 1'b0, 32'h0000_2222, 1'b1, -1);
        run_frame(4'b1000, 1'b0, 32'h0000_3333, 1'b1, 12);
        run_frame(4'b0011, 1'b0, 32'hCAFE_0000, 1'b1, -1);
        repeat (6) run_frame(4'b0011, 1'b1, 32'hCAFE_0001, 1'b1, -1);
        repeat (3) run_frame(4'b0011, 1'b0, 32'hCAFE_0002, 1'b1, -1);
        run_frame(4'b0010, 1'b1, 32'hCAFE_0003, 1'b1, -1);
        run_frame(4'b0010, 1'b0, 32'hCAFE_0004, 1'b1, -1);

        for (int f = 0; f < 70; f++) begin
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, FRAME - 1)) : -1;
            run_frame(N'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                      32'h0, 1'b0, rst_at);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
